// File: rtl/b16_slice_subtractor.sv
// b16_slice_subtractor: computes D = A - B one SLICE-bit slice per clock, chaining the borrow through a register.
// Operands and results move over valid/ready handshakes; the result and flags hold in HOLD until accepted.
module b16_slice_subtractor #(
  parameter int WIDTH = 16,
  parameter int SLICE = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] D,
  output logic             Bout,
  output logic             Z,
  output logic             V
);

  localparam int N = WIDTH / SLICE;
  localparam int IDXW = (N > 1) ? $clog2(N) : 1;
  localparam logic [IDXW-1:0] LAST_IDX = IDXW'(N - 1);

  typedef enum logic [1:0] {IDLE, CALC, HOLD} state_t;

  state_t           r_state;
  state_t           w_stateNext;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic [WIDTH-1:0] r_d;
  logic [IDXW-1:0]  r_idx;
  logic             r_borrow;
  logic             r_bout;
  logic             r_z;
  logic             r_v;

  logic [SLICE-1:0] w_aSlice;
  logic [SLICE-1:0] w_bSlice;
  logic [SLICE-1:0] w_dSlice;
  logic             w_borrowNext;
  logic [WIDTH-1:0] w_dNext;
  logic             w_accept;
  logic             w_lastSlice;

  assign w_accept    = (r_state == IDLE) && in_valid;
  assign w_lastSlice = (r_state == CALC) && (r_idx == LAST_IDX);

  assign w_aSlice = r_a[r_idx*SLICE +: SLICE];
  assign w_bSlice = r_b[r_idx*SLICE +: SLICE];
  // The extra top bit of the (SLICE+1)-bit difference is the borrow out of this slice.
  assign {w_borrowNext, w_dSlice} = {1'b0, w_aSlice} - {1'b0, w_bSlice} - {{SLICE{1'b0}}, r_borrow};

  always_comb begin
    w_dNext = r_d;
    w_dNext[r_idx*SLICE +: SLICE] = w_dSlice;
  end

  always_ff @(posedge clk) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_stateNext;
  end

  always_comb begin
    w_stateNext = r_state;
    in_ready    = 1'b0;
    out_valid   = 1'b0;
    case (r_state)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) w_stateNext = CALC;
      end
      CALC: begin
        if (r_idx == LAST_IDX) w_stateNext = HOLD;
      end
      HOLD: begin
        out_valid = 1'b1;
        if (out_ready) w_stateNext = IDLE;
      end
      default: w_stateNext = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_a      <= '0;
      r_b      <= '0;
      r_d      <= '0;
      r_idx    <= '0;
      r_borrow <= 1'b0;
      r_bout   <= 1'b0;
      r_z      <= 1'b0;
      r_v      <= 1'b0;
    end else begin
      if (w_accept) begin
        r_a      <= A;
        r_b      <= B;
        r_idx    <= '0;
        r_borrow <= 1'b0;
      end
      if (r_state == CALC) begin
        r_d      <= w_dNext;
        r_borrow <= w_borrowNext;
        r_idx    <= w_lastSlice ? '0 : r_idx + 1'b1;
      end
      // Flags are taken from the completed result so they stay frozen for the whole of HOLD.
      if (w_lastSlice) begin
        r_bout <= w_borrowNext;
        r_z    <= (w_dNext == '0);
        r_v    <= (r_a[WIDTH-1] != r_b[WIDTH-1]) && (w_dNext[WIDTH-1] != r_a[WIDTH-1]);
      end
    end
  end

  assign D    = r_d;
  assign Bout = r_bout;
  assign Z    = r_z;
  assign V    = r_v;

endmodule

// File: tb/tb_b16_slice_subtractor.sv
// Testbench for b16_slice_subtractor: table-driven vectors, hand-written corner sequences and a random sweep,
// all results checked through a scoreboard queue filled when operands are accepted.
module tb_b16_slice_subtractor;

  localparam int WIDTH = 16;
  localparam int SLICE = 8;

  logic             clk = 1'b0;
  logic             rst;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] A;
  logic [WIDTH-1:0] B;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] D;
  logic             Bout;
  logic             Z;
  logic             V;

  typedef struct {
    logic [15:0] a;
    logic [15:0] b;
    logic [15:0] d;
    logic        bo;
    logic        z;
    logic        v;
  } vec_t;

  vec_t expQ[$];
  vec_t vecs[5];
  int   errors = 0;
  int   checks = 0;
  int   accepted = 0;
  int   received = 0;
  bit   randStall = 1'b0;

  b16_slice_subtractor #(.WIDTH(WIDTH), .SLICE(SLICE)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .A(A), .B(B),
    .out_valid(out_valid), .out_ready(out_ready),
    .D(D), .Bout(Bout), .Z(Z), .V(V)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Whole-width reference, deliberately not slice based.
  function automatic vec_t model(input logic [15:0] a, input logic [15:0] b);
    vec_t r;
    r.a  = a;
    r.b  = b;
    r.d  = a - b;
    r.bo = (a < b);
    r.z  = (a == b);
    r.v  = (a[15] != b[15]) && (r.d[15] != a[15]);
    return r;
  endfunction

  // One cycle: scoreboard compare at the negedge before a handshake edge, then move to just after the next posedge.
  task automatic tick();
    vec_t e;
    @(negedge clk);
    if (!rst && out_valid && out_ready) begin
      if (expQ.size() == 0) begin
        checkOutput("spurious result", 32'd1, 32'd0);
      end else begin
        e = expQ.pop_front();
        checkOutput("D", 32'(D), 32'(e.d));
        checkOutput("Bout", 32'(Bout), 32'(e.bo));
        checkOutput("Z", 32'(Z), 32'(e.z));
        checkOutput("V", 32'(V), 32'(e.v));
        received++;
      end
    end
    @(posedge clk);
    #1;
    if (randStall) out_ready = ($urandom_range(0, 3) != 0);
  endtask

  task automatic applyStimulus(input vec_t v, input bit push);
    int guard = 0;
    while (!in_ready && guard < 100) begin
      tick();
      guard++;
    end
    if (!in_ready) checkOutput("in_ready timeout", 32'(in_ready), 32'd1);
    in_valid = 1'b1;
    A = v.a;
    B = v.b;
    if (push) begin
      expQ.push_back(v);
      accepted++;
    end
    tick();
    in_valid = 1'b0;
    A = 16'($urandom);
    B = 16'($urandom);
  endtask

  task automatic waitDrain();
    int guard = 0;
    while (expQ.size() != 0 && guard < 200) begin
      tick();
      guard++;
    end
    checkOutput("drain timeout", 32'(expQ.size()), 32'd0);
    tick();
  endtask

  initial begin
    vec_t v;
    vecs[0] = '{a: 16'h0003, b: 16'h0004, d: 16'hFFFF, bo: 1'b1, z: 1'b0, v: 1'b0};
    vecs[1] = '{a: 16'h0400, b: 16'h0300, d: 16'h0100, bo: 1'b0, z: 1'b0, v: 1'b0};
    vecs[2] = '{a: 16'h0100, b: 16'h0001, d: 16'h00FF, bo: 1'b0, z: 1'b0, v: 1'b0};
    vecs[3] = '{a: 16'h0000, b: 16'h0000, d: 16'h0000, bo: 1'b0, z: 1'b1, v: 1'b0};
    vecs[4] = '{a: 16'h8000, b: 16'h0001, d: 16'h7FFF, bo: 1'b0, z: 1'b0, v: 1'b1};

    rst = 1'b1;
    in_valid = 1'b0;
    out_ready = 1'b1;
    A = '0;
    B = '0;
    tick();
    tick();
    checkOutput("reset in_ready", 32'(in_ready), 32'd1);
    checkOutput("reset out_valid", 32'(out_valid), 32'd0);
    checkOutput("reset D", 32'(D), 32'd0);
    checkOutput("reset flags", 32'({Bout, Z, V}), 32'd0);
    rst = 1'b0;
    tick();

    // Latency of the first operation with out_ready tied high.
    applyStimulus(vecs[0], 1'b1);
    checkOutput("in_ready after accept", 32'(in_ready), 32'd0);
    checkOutput("out_valid at t+0", 32'(out_valid), 32'd0);
    tick();
    checkOutput("out_valid at t+1", 32'(out_valid), 32'd0);
    tick();
    checkOutput("out_valid at t+2", 32'(out_valid), 32'd1);
    tick();
    checkOutput("out_valid after handshake", 32'(out_valid), 32'd0);
    checkOutput("in_ready after handshake", 32'(in_ready), 32'd1);
    checkOutput("first result popped", 32'(expQ.size()), 32'd0);

    for (int i = 1; i < 5; i++) begin
      applyStimulus(vecs[i], 1'b1);
      waitDrain();
    end

    // Backpressure: result held for 5 cycles while in_valid pulses are ignored.
    out_ready = 1'b0;
    v = model(16'h1234, 16'h0235);
    applyStimulus(v, 1'b1);
    for (int g = 0; g < 20 && !out_valid; g++) tick();
    for (int c = 0; c < 5; c++) begin
      checkOutput("bp out_valid", 32'(out_valid), 32'd1);
      checkOutput("bp in_ready", 32'(in_ready), 32'd0);
      checkOutput("bp D", 32'(D), 32'h0FFF);
      checkOutput("bp flags", 32'({Bout, Z, V}), 32'd0);
      in_valid = c[0];
      A = 16'hAAAA;
      B = 16'h5555;
      tick();
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    tick();
    checkOutput("bp handshake out_valid", 32'(out_valid), 32'd0);
    checkOutput("bp handshake in_ready", 32'(in_ready), 32'd1);
    checkOutput("bp queue empty", 32'(expQ.size()), 32'd0);
    tick();
    checkOutput("bp pulses ignored", 32'(out_valid), 32'd0);

    // Reset one cycle after accepting; the partial result must vanish.
    v = model(16'h1234, 16'h0001);
    applyStimulus(v, 1'b0);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    checkOutput("mid-reset in_ready", 32'(in_ready), 32'd1);
    checkOutput("mid-reset out_valid", 32'(out_valid), 32'd0);
    checkOutput("mid-reset D", 32'(D), 32'd0);
    checkOutput("mid-reset flags", 32'({Bout, Z, V}), 32'd0);
    v.d = 16'h1233;
    applyStimulus(v, 1'b1);
    waitDrain();

    // Random sweep with random consumer stalls.
    randStall = 1'b1;
    for (int i = 0; i < 1000; i++) begin
      v = model(16'($urandom), 16'($urandom));
      if (i % 50 == 0) v = model(16'($urandom), v.a);
      applyStimulus(v, 1'b1);
    end
    waitDrain();
    randStall = 1'b0;
    out_ready = 1'b1;
    checkOutput("results received", 32'(received), 32'(accepted));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
